// File: rtl/cpu16_bus_pkg.sv
// Shared definitions for masters on the 16-bit CPU memory bus.
// Holds the bus width constant used by the CPU and every bus master, plus the
// state encoding of the block-copy DMA controller.
package cpu16_bus_pkg;

    localparam int unsigned BUS_W = 16;

    // DMA controller state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_RD      = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_WR      = 3'd4;
    localparam logic [2:0] ST_WR_DONE = 3'd5;
    localparam logic [2:0] ST_RELEASE = 3'd6;

    typedef enum logic [2:0] {
        StIdle    = ST_IDLE,
        StReq     = ST_REQ,
        StRd      = ST_RD,
        StRdWait  = ST_RD_WAIT,
        StWr      = ST_WR,
        StWrDone  = ST_WR_DONE,
        StRelease = ST_RELEASE
    } dma_state_e;

endpackage

// File: rtl/cpu16_bus_mux.sv
// 2:1 bus master select for the shared memory bus.
// Ports:
//   grant        - 1 selects the alternate master, 0 selects the CPU
//   cpu_*        - CPU address / write data / write strobe
//   alt_*        - alternate master address / write data / write strobe
//   mem_*        - selected address / write data / write strobe to memory
// Purely combinational; the caller supplies a registered grant.
module cpu16_bus_mux
    import cpu16_bus_pkg::*;
#(
    parameter int unsigned WIDTH = BUS_W
) (
    input  logic             grant,
    input  logic [WIDTH-1:0] cpu_address,
    input  logic [WIDTH-1:0] cpu_data_out,
    input  logic             cpu_write,
    input  logic [WIDTH-1:0] alt_address,
    input  logic [WIDTH-1:0] alt_data_out,
    input  logic             alt_write,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_data_out,
    output logic             mem_write
);

    always_comb begin
        if (grant) begin
            mem_address  = alt_address;
            mem_data_out = alt_data_out;
            mem_write    = alt_write;
        end else begin
            mem_address  = cpu_address;
            mem_data_out = cpu_data_out;
            mem_write    = cpu_write;
        end
    end

endmodule

// File: rtl/dma16_ctrl.sv
// Block-copy DMA engine between the 16-bit CPU and the shared RAM/ROM bus.
// Takes the bus by raising cpu_hold and waiting for cpu_busy, copies len words
// from src to dst in ascending order, then hands the bus back. While the DMA
// does not own the bus the CPU address, write data and strobe pass through.
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   start, src, dst, len   - transfer request (start is a one-cycle pulse)
//   active, done           - transfer in progress / one-cycle completion pulse
//   cpu_hold, cpu_busy     - bus request to the CPU / CPU acknowledge
//   cpu_address/data_out/write - CPU bus master signals
//   mem_address/data_out/write - muxed bus to memory
//   mem_data_in            - memory read data
// Parameter RAM_WAIT: 1 = read data one cycle after the address, 0 = same cycle.
module dma16_ctrl
    import cpu16_bus_pkg::*;
#(
    parameter int unsigned RAM_WAIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BUS_W-1:0] src,
    input  logic [BUS_W-1:0] dst,
    input  logic [BUS_W-1:0] len,
    output logic             active,
    output logic             done,
    output logic             cpu_hold,
    input  logic             cpu_busy,
    input  logic [BUS_W-1:0] cpu_address,
    input  logic [BUS_W-1:0] cpu_data_out,
    input  logic             cpu_write,
    output logic [BUS_W-1:0] mem_address,
    output logic [BUS_W-1:0] mem_data_out,
    output logic             mem_write,
    input  logic [BUS_W-1:0] mem_data_in
);

    dma_state_e state_q, state_d;

    logic [BUS_W-1:0] sa_q, sa_d;
    logic [BUS_W-1:0] da_q, da_d;
    logic [BUS_W-1:0] cnt_q, cnt_d;
    logic [BUS_W-1:0] dma_addr_q, dma_addr_d;
    logic [BUS_W-1:0] dma_dout_q, dma_dout_d;
    logic             dma_we_q, dma_we_d;
    logic             grant_q, grant_d;
    logic             hold_q, hold_d;
    logic             active_q, active_d;
    logic             done_q, done_d;

    always_comb begin
        state_d    = state_q;
        sa_d       = sa_q;
        da_d       = da_q;
        cnt_d      = cnt_q;
        dma_addr_d = dma_addr_q;
        dma_dout_d = dma_dout_q;
        dma_we_d   = dma_we_q;
        grant_d    = grant_q;
        hold_d     = hold_q;
        active_d   = active_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (len != '0) begin
                        sa_d     = src;
                        da_d     = dst;
                        cnt_d    = len;
                        active_d = 1'b1;
                        hold_d   = 1'b1;
                        state_d  = StReq;
                    end else begin
                        // Null transfer: complete without touching the bus.
                        done_d = 1'b1;
                    end
                end
            end

            StReq: begin
                // busy may already be high (e.g. from CPU reset); that counts too.
                if (cpu_busy && hold_q) begin
                    grant_d = 1'b1;
                    state_d = StRd;
                end
            end

            StRd: begin
                dma_addr_d = sa_q;
                state_d    = (RAM_WAIT != 0) ? StRdWait : StWr;
            end

            StRdWait: begin
                state_d = StWr;
            end

            StWr: begin
                dma_dout_d = mem_data_in;
                dma_addr_d = da_q;
                dma_we_d   = 1'b1;
                state_d    = StWrDone;
            end

            StWrDone: begin
                dma_we_d = 1'b0;
                sa_d     = sa_q + 16'd1;
                da_d     = da_q + 16'd1;
                cnt_d    = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    // Drop grant one cycle ahead of hold so the bus owns exactly
                    // four (or three) cycles per word; hold still covers RELEASE.
                    grant_d = 1'b0;
                    state_d = StRelease;
                end else begin
                    state_d = StRd;
                end
            end

            StRelease: begin
                grant_d  = 1'b0;
                hold_d   = 1'b0;
                done_d   = 1'b1;
                active_d = 1'b0;
                state_d  = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            sa_q       <= '0;
            da_q       <= '0;
            cnt_q      <= '0;
            dma_addr_q <= '0;
            dma_dout_q <= '0;
            dma_we_q   <= 1'b0;
            grant_q    <= 1'b0;
            hold_q     <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sa_q       <= sa_d;
            da_q       <= da_d;
            cnt_q      <= cnt_d;
            dma_addr_q <= dma_addr_d;
            dma_dout_q <= dma_dout_d;
            dma_we_q   <= dma_we_d;
            grant_q    <= grant_d;
            hold_q     <= hold_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    assign active   = active_q;
    assign done     = done_q;
    assign cpu_hold = hold_q;

    cpu16_bus_mux #(
        .WIDTH (BUS_W)
    ) u_bus_mux (
        .grant        (grant_q),
        .cpu_address  (cpu_address),
        .cpu_data_out (cpu_data_out),
        .cpu_write    (cpu_write),
        .alt_address  (dma_addr_q),
        .alt_data_out (dma_dout_q),
        .alt_write    (dma_we_q),
        .mem_address  (mem_address),
        .mem_data_out (mem_data_out),
        .mem_write    (mem_write)
    );

endmodule
